// File: rtl/ps2_key_assembler.sv
// ps2_key_assembler
//
// Assembles the raw PS/2 scan-code byte stream into 65-bit key events.
// Prefix bytes (E0, F0), the 8-byte PAUSE sequence (E1 ...) and the
// multi-byte PRNSCR make/break sequences are grouped into one event. Each
// event updates ps2_key[63:0] with the byte history (newest byte in [7:0])
// and inverts ps2_key[64].
//
// Optional build macro: PS2_RESPONSE_FILTER_EN
//   When defined, keyboard response bytes (FA, AA, FE, EE, 00, FF) that
//   arrive while no sequence is in progress are dropped silently.
//
// Parameters:
//   TIMEOUT    clk_sys cycles allowed between bytes of one sequence before
//              the partial sequence is abandoned
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   synchronous, active-high reset
//   rx_data    in   [7:0] received PS/2 byte
//   rx_valid   in   one-cycle strobe, rx_data valid this cycle
//   ps2_key    out  [64] event toggle, [63:0] byte history of last event
//   key_strobe out  one-cycle pulse alongside every ps2_key update
//   busy       out  high while a partial sequence is held

module ps2_key_assembler #(
   parameter int TIMEOUT = 1800000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [64:0] ps2_key,
   output logic        key_strobe,
   output logic        busy
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_PREFIX  = 3'd1;
   localparam logic [2:0] ST_PAUSE   = 3'd2;
   localparam logic [2:0] ST_PRN_MK  = 3'd3;
   localparam logic [2:0] ST_PRN_BRK = 3'd4;

   localparam int         CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT - 1);

   localparam logic [63:0] HIST_PRN_MK  = 64'h0000_0000_0000_E012;
   localparam logic [63:0] HIST_PRN_BRK = 64'h0000_0000_00E0_F07C;

   logic [2:0]       state;
   logic [63:0]      history;
   logic [2:0]       seq_cnt;
   logic [CNT_W-1:0] to_cnt;

   logic [2:0]       nxt_state;
   logic [63:0]      nxt_hist;
   logic [2:0]       nxt_seq;
   logic             fire;
   logic             reproc;
   logic             generic;
   logic             from_idle;
   logic             drop;
   logic [63:0]      base;
   logic [63:0]      shifted;
   logic             timeout_hit;

   // Byte expected at position idx of the PRNSCR make tail (after E0 12).
   function automatic logic [7:0] prn_mk_byte(input logic [2:0] idx);
      logic [7:0] b;
      b = (idx == 3'd0) ? 8'hE0 : 8'h7C;
      return b;
   endfunction

   // Byte expected at position idx of the PRNSCR break tail (after E0 F0 7C).
   function automatic logic [7:0] prn_brk_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'hE0;
         3'd1:    b = 8'hF0;
         default: b = 8'h12;
      endcase
      return b;
   endfunction

`ifdef PS2_RESPONSE_FILTER_EN
   // Keyboard command responses and error codes, not key data.
   function automatic logic is_response(input logic [7:0] b);
      logic r;
      r = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hFE) ||
          (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
      return r;
   endfunction
`endif

   assign busy = (state != ST_IDLE);

   // A lone idle cycle can only expire the sequence; an arriving byte
   // always takes priority and restarts the count.
   assign timeout_hit = busy && !rx_valid && (to_cnt == CNT_HIT);

   always_comb begin
      nxt_state = state;
      nxt_hist  = history;
      nxt_seq   = seq_cnt;
      fire      = 1'b0;
      reproc    = 1'b0;
      generic   = 1'b0;
      from_idle = 1'b0;
      drop      = 1'b0;
      base      = 64'd0;
      shifted   = 64'd0;

      if (rx_valid) begin
         case (state)
            ST_PAUSE: begin
               nxt_hist = {history[55:0], rx_data};
               if (seq_cnt == 3'd7) begin
                  fire      = 1'b1;
                  nxt_state = ST_IDLE;
               end else begin
                  nxt_seq = seq_cnt + 3'd1;
               end
            end
            ST_PRN_MK: begin
               if (rx_data == prn_mk_byte(seq_cnt)) begin
                  nxt_hist = {history[55:0], rx_data};
                  if (seq_cnt == 3'd1) begin
                     fire      = 1'b1;
                     nxt_state = ST_IDLE;
                  end else begin
                     nxt_seq = seq_cnt + 3'd1;
                  end
               end else begin
                  reproc = 1'b1;
               end
            end
            ST_PRN_BRK: begin
               if (rx_data == prn_brk_byte(seq_cnt)) begin
                  nxt_hist = {history[55:0], rx_data};
                  if (seq_cnt == 3'd2) begin
                     fire      = 1'b1;
                     nxt_state = ST_IDLE;
                  end else begin
                     nxt_seq = seq_cnt + 3'd1;
                  end
               end else begin
                  reproc = 1'b1;
               end
            end
            default: generic = 1'b1;
         endcase

         // IDLE/PREFIX handling; a PRNSCR mismatch lands here too, with the
         // partial sequence thrown away and the byte treated as a fresh start.
         if (generic || reproc) begin
            from_idle = (state != ST_PREFIX) || reproc;
            base      = from_idle ? 64'd0 : history;
            shifted   = {base[55:0], rx_data};
`ifdef PS2_RESPONSE_FILTER_EN
            drop      = from_idle && is_response(rx_data);
`else
            drop      = 1'b0;
`endif
            nxt_seq   = 3'd0;
            if (drop) begin
               nxt_state = ST_IDLE;
               nxt_hist  = base;
            end else if ((rx_data == 8'hE0) || (rx_data == 8'hF0)) begin
               nxt_state = ST_PREFIX;
               nxt_hist  = shifted;
            end else if ((rx_data == 8'hE1) && from_idle) begin
               nxt_state = ST_PAUSE;
               nxt_hist  = shifted;
               nxt_seq   = 3'd1;
            end else if (shifted == HIST_PRN_MK) begin
               nxt_state = ST_PRN_MK;
               nxt_hist  = shifted;
            end else if (shifted == HIST_PRN_BRK) begin
               nxt_state = ST_PRN_BRK;
               nxt_hist  = shifted;
            end else begin
               nxt_state = ST_IDLE;
               nxt_hist  = shifted;
               fire      = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         history    <= 64'd0;
         seq_cnt    <= 3'd0;
         to_cnt     <= '0;
         ps2_key    <= 65'd0;
         key_strobe <= 1'b0;
      end else begin
         key_strobe <= fire;
         if (fire) begin
            ps2_key <= {~ps2_key[64], nxt_hist};
         end

         if (rx_valid) begin
            to_cnt <= '0;
         end else if (busy && (to_cnt != CNT_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (timeout_hit) begin
            state   <= ST_IDLE;
            history <= 64'd0;
            seq_cnt <= 3'd0;
         end else begin
            state   <= nxt_state;
            history <= nxt_hist;
            seq_cnt <= nxt_seq;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_assembler.sv
// Self-checking bench for ps2_key_assembler. A byte-list scoreboard model
// predicts ps2_key, key_strobe and busy for every clock cycle.
module tb_ps2_key_assembler;

   localparam int TB_TIMEOUT = 16;
`ifdef PS2_RESPONSE_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [64:0] ps2_key;
   logic        key_strobe;
   logic        busy;

   ps2_key_assembler #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .busy       (busy)
   );

   always #5 clk_sys = ~clk_sys;

   int vectors = 0;
   int errors  = 0;

   // Reference model state.
   logic [7:0]  pend[$];
   logic [64:0] m_key;
   logic        m_strobe;
   logic        m_busy;
   int          gap;

   // Stimulus list: {valid, byte}.
   logic [8:0]  stim[$];

   function automatic bit is_resp(input logic [7:0] b);
      return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hFE) ||
             (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   // 0: incomplete, 1: complete, 2: PRNSCR mismatch (retry last byte alone)
   function automatic int classify();
      logic [7:0] mk [4];
      logic [7:0] bk [6];
      int n;
      n = pend.size();
      mk = '{8'hE0, 8'h12, 8'hE0, 8'h7C};
      bk = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12};
      if (pend[0] == 8'hE1) return (n == 8) ? 1 : 0;
      if (n >= 2 && pend[0] == 8'hE0 && pend[1] == 8'h12) begin
         for (int i = 2; i < n; i++) if (pend[i] != mk[i]) return 2;
         return (n == 4) ? 1 : 0;
      end
      if (n >= 3 && pend[0] == 8'hE0 && pend[1] == 8'hF0 && pend[2] == 8'h7C) begin
         for (int i = 3; i < n; i++) if (pend[i] != bk[i]) return 2;
         return (n == 6) ? 1 : 0;
      end
      if (pend[n-1] == 8'hE0 || pend[n-1] == 8'hF0) return 0;
      return 1;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      bit again;
      int c;
      logic [63:0] val;
      again = 1'b1;
      while (again) begin
         again = 1'b0;
         if (pend.size() == 0 && FILT && is_resp(b)) return;
         pend.push_back(b);
         c = classify();
         if (c == 1) begin
            val = 64'd0;
            foreach (pend[i]) val = {val[55:0], pend[i]};
            m_key    = {~m_key[64], val};
            m_strobe = 1'b1;
            pend.delete();
         end else if (c == 2) begin
            pend.delete();
            again = 1'b1;
         end
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] b);
      m_strobe = 1'b0;
      if (v) begin
         gap = 0;
         model_byte(b);
      end else if (pend.size() != 0) begin
         gap++;
         if (gap >= TB_TIMEOUT) pend.delete();
      end
      m_busy = (pend.size() != 0);
   endtask

   // Drive one cycle and advance the model; outputs are stable at return.
   task automatic apply(input bit v, input logic [7:0] b);
      rx_valid = v;
      rx_data  = v ? b : 8'($urandom);
      model_step(v, b);
      @(posedge clk_sys);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      pend.delete();
      m_key    = 65'd0;
      m_strobe = 1'b0;
      m_busy   = 1'b0;
      gap      = 0;
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] b);
      stim.push_back({1'b1, b});
   endtask

   task automatic push_gap(input int n);
      for (int i = 0; i < n; i++) stim.push_back(9'd0);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (ps2_key !== 65'd0 || key_strobe !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: key=%h strobe=%b busy=%b, want 0/0/0", ps2_key, key_strobe, busy);
      end
      apply(1'b1, 8'h1C);
      vectors++;
      if (ps2_key !== {1'b1, 64'h1C} || key_strobe !== 1'b1) begin
         errors++;
         $display("FAIL single_key: key=%h strobe=%b, want %h/1", ps2_key, key_strobe, {1'b1, 64'h1C});
      end
      apply(1'b0, 8'h00);
      vectors++;
      if (key_strobe !== 1'b0 || ps2_key !== {1'b1, 64'h1C}) begin
         errors++;
         $display("FAIL single_key_hold: key=%h strobe=%b", ps2_key, key_strobe);
      end
   endtask

   task automatic test_prefix_release();
      int ev = 0;
      stim.delete();
      push_b(8'hE0); push_gap(9); push_b(8'hF0); push_gap(9); push_b(8'h75); push_gap(2);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         ev += int'(key_strobe);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL prefix cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
      end
      vectors++;
      if (ev !== 1 || ps2_key[63:0] !== 64'hE0F075) begin
         errors++;
         $display("FAIL prefix_event: events=%0d key=%h want 1 / E0F075", ev, ps2_key[63:0]);
      end
   endtask

   task automatic test_prn_pause();
      logic [63:0] got_prn = 64'd0;
      stim.delete();
      push_b(8'hE0); push_b(8'h12); push_b(8'hE0); push_b(8'h7C);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL prn cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
      end
      got_prn = ps2_key[63:0];
      vectors++;
      if (got_prn !== 64'h0000_0000_E012_E07C) begin
         errors++;
         $display("FAIL prn_value: got %h want 00000000E012E07C", got_prn);
      end
      stim.delete();
      push_b(8'hE1); push_b(8'h14); push_b(8'h77); push_b(8'hE1);
      push_b(8'hF0); push_b(8'h14); push_b(8'hF0); push_b(8'h77); push_gap(1);
      push_b(8'hE0); push_b(8'hF0); push_b(8'h7C); push_b(8'hE0); push_b(8'hF0); push_b(8'h12);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL pause cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
         if (i == 7) begin
            vectors++;
            if (ps2_key[63:0] !== 64'hE114_77E1_F014_F077) begin
               errors++;
               $display("FAIL pause_value: got %h want E11477E1F014F077", ps2_key[63:0]);
            end
         end
      end
      vectors++;
      if (ps2_key[63:0] !== 64'h0000_E0F0_7CE0_F012) begin
         errors++;
         $display("FAIL prn_brk_value: got %h want 0000E0F07CE0F012", ps2_key[63:0]);
      end
   endtask

   task automatic test_prn_mismatch();
      int ev = 0;
      logic t0;
      t0 = ps2_key[64];
      stim.delete();
      push_b(8'hE0); push_b(8'h12); push_b(8'h1C); push_gap(1);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         ev += int'(key_strobe);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL mismatch cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
      end
      vectors++;
      if (ev !== 1 || ps2_key !== {~t0, 64'h1C}) begin
         errors++;
         $display("FAIL mismatch_event: events=%0d key=%h want 1 / %h", ev, ps2_key, {~t0, 64'h1C});
      end
   endtask

   task automatic test_timeout();
      stim.delete();
      push_b(8'hF0); push_gap(TB_TIMEOUT); push_b(8'h1C);
      push_b(8'hF0); push_gap(TB_TIMEOUT - 1); push_b(8'h1C); push_gap(1);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL timeout cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
         if (i == TB_TIMEOUT) begin
            vectors++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL timeout_busy: busy=%b want 0", busy);
            end
         end
         if (i == TB_TIMEOUT + 1) begin
            vectors++;
            if (ps2_key[63:0] !== 64'h1C) begin
               errors++;
               $display("FAIL timeout_discard: got %h want 1C", ps2_key[63:0]);
            end
         end
      end
      vectors++;
      if (ps2_key[63:0] !== 64'hF01C) begin
         errors++;
         $display("FAIL timeout_edge_byte: got %h want F01C", ps2_key[63:0]);
      end
   endtask

   task automatic test_filter();
      int ev = 0;
      stim.delete();
      push_b(8'hFA); push_b(8'hAA); push_b(8'h29); push_gap(1);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         ev += int'(key_strobe);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL filter cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
      end
      vectors++;
      if (ev !== (FILT ? 1 : 3) || ps2_key[63:0] !== 64'h29) begin
         errors++;
         $display("FAIL filter_events: events=%0d key=%h want %0d / 29", ev, ps2_key[63:0], FILT ? 1 : 3);
      end
   endtask

   task automatic test_back_to_back();
      stim.delete();
      push_b(8'h1C); push_b(8'h32); push_b(8'hF0); push_b(8'h21); push_b(8'h00); push_b(8'hE0);
      push_b(8'h12); push_b(8'hE0); push_b(8'h7C); push_b(8'h45);
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL b2b cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply(1'b1, 8'hE0);
      apply(1'b1, 8'hF0);
      do_reset();
      vectors++;
      if (ps2_key !== 65'd0 || key_strobe !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: key=%h strobe=%b busy=%b want 0/0/0", ps2_key, key_strobe, busy);
      end
      apply(1'b1, 8'h1C);
      vectors++;
      if (ps2_key !== {1'b1, 64'h1C}) begin
         errors++;
         $display("FAIL reset_mid_next: key=%h want %h", ps2_key, {1'b1, 64'h1C});
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [10];
      logic [7:0] b;
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h7C, 8'hE0, 8'h1C, 8'hAA, 8'hFA, 8'h00};
      stim.delete();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) < 6) b = pool[$urandom_range(0, 9)];
         else b = 8'($urandom);
         push_b(b);
         case ($urandom_range(0, 5))
            0, 1:    ;
            2, 3:    push_gap($urandom_range(1, 4));
            default: push_gap($urandom_range(TB_TIMEOUT - 2, TB_TIMEOUT + 2));
         endcase
      end
      for (int i = 0; i < stim.size(); i++) begin
         apply(stim[i][8], stim[i][7:0]);
         vectors++;
         if (ps2_key !== m_key || key_strobe !== m_strobe || busy !== m_busy) begin
            errors++;
            $display("FAIL random cyc%0d: key=%h strobe=%b busy=%b want %h/%b/%b",
                     i, ps2_key, key_strobe, busy, m_key, m_strobe, m_busy);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_prefix_release();
      test_prn_pause();
      test_prn_mismatch();
      test_timeout();
      test_filter();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
